// File: rtl/apb_region_completer.sv
// APB4 completer: word memory, wait states, align/range/PPROT-region checks.
// Define APB_ERR_CNT_EN to add the err_cnt / err_cause outputs.
module apb_region_completer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1,
    parameter int NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*3-1:0] REGION_PROT = {3'b111, 3'b000}
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
`ifdef APB_ERR_CNT_EN
    ,
    output logic [15:0]             err_cnt,
    output logic [1:0]              err_cause
`endif
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ALIGNBITS  = $clog2(STRB_WIDTH);
    localparam int RBITS      = $clog2(NUM_REGIONS);
    localparam int WW         = ADDR_WIDTH - ALIGNBITS;
    localparam int IW         = $clog2(DEPTH);
    localparam logic [WW-1:0] WMASK = {WW{1'b1}} >> RBITS;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [IW-1:0]         r_idx;
    logic                  r_write;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [STRB_WIDTH-1:0] r_strb;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [WW-1:0] w_widx;
    logic [2:0]    w_req;
    logic          w_misal;
    logic          w_range;
    logic          w_prot;
    logic          w_err;
    logic          w_setup;
    logic          w_ready;

    // Region bits alias onto the same words; only protection differs.
    assign w_widx = PADDR[ADDR_WIDTH-1:ALIGNBITS] & WMASK;

    generate
        if (ALIGNBITS > 0) begin : g_align
            assign w_misal = |PADDR[ALIGNBITS-1:0];
        end else begin : g_noalign
            assign w_misal = 1'b0;
        end
        if (RBITS > 0) begin : g_reg
            logic [RBITS-1:0] w_region;
            assign w_region = PADDR[ADDR_WIDTH-1 -: RBITS];
            assign w_req    = REGION_PROT[int'(w_region)*3 +: 3];
        end else begin : g_noreg
            assign w_req = REGION_PROT[2:0];
        end
    endgenerate

    assign w_range = 32'(w_widx) >= 32'(DEPTH);
    assign w_prot  = (PPROT & w_req) != w_req;
    assign w_err   = w_misal | w_range | w_prot;
    assign w_setup = (r_state == S_IDLE) && PSEL && !PENABLE;

    assign w_ready = (r_state == S_ACCESS) && (r_cnt == 4'd0)
                     && PSEL && PENABLE;
    assign PREADY  = w_ready;
    assign PSLVERR = w_ready && r_err;
    assign PRDATA  = (w_ready && !r_write) ? r_rdata : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_strb  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_idx   <= w_widx[IW-1:0];
                        r_write <= PWRITE;
                        r_err   <= w_err;
                        r_wdata <= PWDATA;
                        r_strb  <= PSTRB;
                        r_rdata <= (w_err || PWRITE) ? '0
                                   : r_mem[w_widx[IW-1:0]];
                    end
                end
                S_ACCESS: begin
                    if (!PSEL) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (PENABLE) begin
                        r_state <= S_IDLE;
                        if (r_write && !r_err) begin
                            for (int n = 0; n < STRB_WIDTH; n++) begin
                                if (r_strb[n])
                                    r_mem[r_idx][8*n +: 8] <= r_wdata[8*n +: 8];
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef APB_ERR_CNT_EN
    logic [1:0]  r_cause_q;
    logic [15:0] r_err_cnt;
    logic [1:0]  r_err_cause;
    logic [1:0]  w_cause;

    assign w_cause = w_misal ? 2'd1 : w_range ? 2'd2 : w_prot ? 2'd3 : 2'd0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cause_q   <= '0;
            r_err_cnt   <= '0;
            r_err_cause <= '0;
        end else begin
            if (w_setup) r_cause_q <= w_cause;
            if (PSLVERR) begin
                r_err_cause <= r_cause_q;
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign err_cnt   = r_err_cnt;
    assign err_cause = r_err_cause;
`endif

endmodule

// File: tb/tb_apb_region_completer.sv
// Directed bench for apb_region_completer (WAIT_STATES=1 and 0 instances).
// Define APB_ERR_CNT_EN to also check err_cnt / err_cause.
module tb_apb_region_completer;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;

    logic        z_PSEL, z_PENABLE, z_PWRITE;
    logic [15:0] z_PADDR;
    logic [31:0] z_PWDATA;
    logic [3:0]  z_PSTRB;
    logic [2:0]  z_PPROT;
    logic [31:0] z_PRDATA;
    logic        z_PREADY, z_PSLVERR;

`ifdef APB_ERR_CNT_EN
    logic [15:0] err_cnt, z_err_cnt;
    logic [1:0]  err_cause, z_err_cause;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 PCLK = ~PCLK;

    apb_region_completer #(.WAIT_STATES(1)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
`ifdef APB_ERR_CNT_EN
        , .err_cnt(err_cnt), .err_cause(err_cause)
`endif
    );

    apb_region_completer #(.WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(z_PSEL), .PENABLE(z_PENABLE),
        .PWRITE(z_PWRITE), .PADDR(z_PADDR), .PWDATA(z_PWDATA),
        .PSTRB(z_PSTRB), .PPROT(z_PPROT), .PRDATA(z_PRDATA),
        .PREADY(z_PREADY), .PSLVERR(z_PSLVERR)
`ifdef APB_ERR_CNT_EN
        , .err_cnt(z_err_cnt), .err_cause(z_err_cause)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at posedge+1; returns at posedge+1 after the completion edge.
    task automatic apb(input logic wr, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [2:0] p, output logic [31:0] rd,
                       output logic err, output int acc);
        bit done;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = a; PWDATA = d; PSTRB = s; PPROT = p;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        acc = 1; rd = '0; err = 1'b0; done = 1'b0;
        while (!done) begin
            @(negedge PCLK);
            if (PREADY) begin
                rd = PRDATA; err = PSLVERR; done = 1'b1;
            end else begin
                chk("prdata_in_wait", PRDATA, 32'h0);
                if (acc >= 16) begin
                    chk("pready_timeout", 32'(acc), 32'h0);
                    done = 1'b1;
                end else begin
                    @(posedge PCLK); #1;
                    acc++;
                end
            end
        end
        @(posedge PCLK); #1;
    endtask

    task automatic idle();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic do_wr(input string tag, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] p, input logic exp_err);
        logic [31:0] rd; logic err; int acc;
        apb(1'b1, a, d, s, p, rd, err, acc);
        chk({tag, "_slverr"}, 32'(err), 32'(exp_err));
    endtask

    task automatic do_rd(input string tag, input logic [15:0] a,
                         input logic [2:0] p, input logic [31:0] exp_d,
                         input logic exp_err);
        logic [31:0] rd; logic err; int acc;
        apb(1'b0, a, 32'h0, 4'h0, p, rd, err, acc);
        chk({tag, "_data"}, rd, exp_d);
        chk({tag, "_slverr"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] rd; logic err; int acc;
        PRESETn = 1'b0;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0;
        PWDATA = '0; PSTRB = '0; PPROT = '0;
        z_PSEL = 0; z_PENABLE = 0; z_PWRITE = 0; z_PADDR = '0;
        z_PWDATA = '0; z_PSTRB = '0; z_PPROT = '0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_pready", 32'(PREADY), 32'h0);
        chk("rst_pslverr", 32'(PSLVERR), 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pready_ws0", 32'(z_PREADY), 32'h0);
`ifdef APB_ERR_CNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("rst_err_cause", 32'(err_cause), 32'h0);
`endif
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        apb(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 3'b000, rd, err, acc);
        chk("wr4_slverr", 32'(err), 32'h0);
        chk("wr4_latency", 32'(acc), 32'd2);
        idle();
        apb(1'b0, 16'h0004, 32'h0, 4'h0, 3'b000, rd, err, acc);
        chk("rd4_data", rd, 32'hDEADBEEF);
        chk("rd4_slverr", 32'(err), 32'h0);
        chk("rd4_latency", 32'(acc), 32'd2);
        idle();

        do_wr("wr4_strb5", 16'h0004, 32'h11223344, 4'b0101, 3'b000, 1'b0);
        idle();
        do_rd("rd4_merge", 16'h0004, 3'b000, 32'hDE22BE44, 1'b0);

        do_rd("rd6_misal", 16'h0006, 3'b000, 32'h0, 1'b1);
`ifdef APB_ERR_CNT_EN
        chk("cause_align", 32'(err_cause), 32'd1);
`endif

        do_wr("wr8000_ok", 16'h8000, 32'hCAFEF00D, 4'hF, 3'b111, 1'b0);
        do_wr("wr8000_prot", 16'h8000, 32'h12345678, 4'hF, 3'b011, 1'b1);
`ifdef APB_ERR_CNT_EN
        chk("cause_prot", 32'(err_cause), 32'd3);
`endif
        do_rd("rd8000_p7", 16'h8000, 3'b111, 32'hCAFEF00D, 1'b0);
        do_rd("rd8000_p6", 16'h8000, 3'b110, 32'h0, 1'b1);
        do_rd("rd0000_alias", 16'h0000, 3'b000, 32'hCAFEF00D, 1'b0);

        do_wr("wr3fc_last", 16'h03FC, 32'hA5A5A5A5, 4'hF, 3'b000, 1'b0);
        do_rd("rd3fc_last", 16'h03FC, 3'b000, 32'hA5A5A5A5, 1'b0);
        do_rd("rd400_range", 16'h0400, 3'b000, 32'h0, 1'b1);
`ifdef APB_ERR_CNT_EN
        chk("cause_range", 32'(err_cause), 32'd2);
`endif
        do_wr("wr400_range", 16'h0400, 32'h99999999, 4'hF, 3'b000, 1'b1);
        do_rd("rd0000_after", 16'h0000, 3'b000, 32'hCAFEF00D, 1'b0);

        do_wr("wr4_strb0", 16'h0004, 32'hFFFFFFFF, 4'h0, 3'b000, 1'b0);
        do_rd("rd4_strb0", 16'h0004, 3'b000, 32'hDE22BE44, 1'b0);

        do_wr("b2b_wr", 16'h0020, 32'h00000001, 4'hF, 3'b000, 1'b0);
        do_rd("b2b_rd", 16'h0020, 3'b000, 32'h00000001, 1'b0);
        idle();
`ifdef APB_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), 32'd5);
`endif

        z_PSEL = 1'b1; z_PENABLE = 1'b0; z_PWRITE = 1'b1;
        z_PADDR = 16'h0020; z_PWDATA = 32'h1; z_PSTRB = 4'hF;
        @(posedge PCLK); #1;
        z_PENABLE = 1'b1;
        @(negedge PCLK);
        chk("ws0_wr_pready", 32'(z_PREADY), 32'h1);
        chk("ws0_wr_slverr", 32'(z_PSLVERR), 32'h0);
        @(posedge PCLK); #1;
        z_PENABLE = 1'b0; z_PWRITE = 1'b0;
        @(posedge PCLK); #1;
        z_PENABLE = 1'b1;
        @(negedge PCLK);
        chk("ws0_rd_pready", 32'(z_PREADY), 32'h1);
        chk("ws0_rd_data", z_PRDATA, 32'h1);
        @(posedge PCLK); #1;
        z_PSEL = 1'b0; z_PENABLE = 1'b0;
        @(negedge PCLK);
        chk("ws0_idle_pready", 32'(z_PREADY), 32'h0);
        @(posedge PCLK); #1;

        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 16'h0004; PWDATA = 32'h55555555; PSTRB = 4'hF;
        PPROT = 3'b000;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("rstmid_wait_pready", 32'(PREADY), 32'h0);
        #2 PRESETn = 1'b0;
        #1;
        chk("rstmid_pready", 32'(PREADY), 32'h0);
        chk("rstmid_prdata", PRDATA, 32'h0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("rstmid_after_pready", 32'(PREADY), 32'h0);
        @(posedge PCLK); #1;
        idle();
`ifdef APB_ERR_CNT_EN
        chk("rstmid_err_cnt", 32'(err_cnt), 32'h0);
`endif
        do_rd("rstmid_rd4", 16'h0004, 3'b000, 32'h0, 1'b0);
        do_rd("rstmid_rd3fc", 16'h03FC, 3'b000, 32'h0, 1'b0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
